imem_stream_loader: RTL

- Hardware program loader for the single-cycle CPU's instruction memory; replaces simulation-only `$readmemh` preloading.
- Receives a framed byte stream over a valid/ready interface and assembles big-endian 32-bit words.
- Writes each word into instruction memory through a dedicated write port.
- Holds the CPU in reset until a complete frame with a correct checksum has been loaded.

---
 rtl/imem_stream_loader.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/imem_stream_loader.sv
// imem_stream_loader
//
// Loads a program into the instruction memory from a framed byte stream and
// keeps the CPU in reset until the whole frame has arrived and its checksum
// has been verified.
//
// Frame: SYNC_BYTE, LEN_HI, LEN_LO (N words, big-endian), 4*N data bytes
// (each word MSB first), CSUM (XOR of all data bytes, 8'h00 when N == 0).
//
// Handshake: a byte moves only on a cycle where in_valid && in_ready are both
// high. in_ready depends only on the state, never on in_valid. Cycles with
// in_valid low change nothing.
//
// Ports
//   clk, rst      clock and synchronous active-high reset
//   in_data       stream byte
//   in_valid      in_data holds a byte this cycle
//   in_ready      loader accepts a byte this cycle (low once DONE or ERROR)
//   im_we         one-cycle write pulse per assembled word
//   im_addr       word index being written (0-based)
//   im_wdata      word being written
//   cpu_rst       CPU reset, released only after a good frame
//   done          frame loaded and checksum correct (held until rst)
//   err           frame rejected (held until rst)
//   words_loaded  number of writes issued for the current frame
//   dbg_state     current FSM state, for debug and checkers
module imem_stream_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  im_we,
    output logic [ADDR_WIDTH-1:0] im_addr,
    output logic [31:0]           im_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           words_loaded,
    output logic [2:0]            dbg_state
);

    localparam int          DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_e;

    state_e                state_q;
    logic [7:0]            len_hi_q;
    logic [15:0]           len_q;
    logic [1:0]            byte_cnt_q;
    logic [23:0]           word_q;      // first three bytes of the word in flight
    logic [7:0]            csum_q;
    logic                  im_we_q;
    logic [ADDR_WIDTH-1:0] im_addr_q;
    logic [31:0]           im_wdata_q;
    logic [15:0]           words_loaded_q;
    logic                  done_q;
    logic                  err_q;
    logic                  cpu_rst_q;

    logic                  accept;
    logic [15:0]           len_d;
    logic [31:0]           word_d;
    logic [7:0]            csum_d;

    always_comb begin
        in_ready = (state_q != S_DONE) && (state_q != S_ERROR);
        accept   = in_valid && in_ready;
        len_d    = {len_hi_q, in_data};
        word_d   = {word_q, in_data};
        csum_d   = csum_q ^ in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            len_hi_q       <= 8'd0;
            len_q          <= 16'd0;
            byte_cnt_q     <= 2'd0;
            word_q         <= 24'd0;
            csum_q         <= 8'd0;
            im_we_q        <= 1'b0;
            im_addr_q      <= '0;
            im_wdata_q     <= 32'd0;
            words_loaded_q <= 16'd0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
            cpu_rst_q      <= 1'b1;
        end else begin
            // Write strobe is a single-cycle pulse unless re-armed below.
            im_we_q <= 1'b0;
            if (accept) begin
                case (state_q)
                    S_IDLE: begin
                        if (in_data == SYNC_BYTE) begin
                            state_q        <= S_LEN_HI;
                            csum_q         <= 8'd0;
                            words_loaded_q <= 16'd0;
                            byte_cnt_q     <= 2'd0;
                        end
                    end
                    S_LEN_HI: begin
                        len_hi_q <= in_data;
                        state_q  <= S_LEN_LO;
                    end
                    S_LEN_LO: begin
                        len_q <= len_d;
                        if ({1'b0, len_d} > DEPTH_W) begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end else if (len_d == 16'd0) begin
                            state_q <= S_CSUM;
                        end else begin
                            state_q <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        csum_q     <= csum_d;
                        word_q     <= word_d[23:0];
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            // words_loaded_q still holds the index of this word.
                            im_we_q        <= 1'b1;
                            im_addr_q      <= words_loaded_q[ADDR_WIDTH-1:0];
                            im_wdata_q     <= word_d;
                            words_loaded_q <= words_loaded_q + 16'd1;
                            if (words_loaded_q + 16'd1 == len_q) begin
                                state_q <= S_CSUM;
                            end
                        end
                    end
                    S_CSUM: begin
                        if (in_data == csum_q) begin
                            state_q   <= S_DONE;
                            done_q    <= 1'b1;
                            cpu_rst_q <= 1'b0;
                        end else begin
                            state_q <= S_ERROR;
                            err_q   <= 1'b1;
                        end
                    end
                    default: begin
                        // DONE / ERROR never accept (in_ready low).
                    end
                endcase
            end
        end
    end

    always_comb begin
        im_we        = im_we_q;
        im_addr      = im_addr_q;
        im_wdata     = im_wdata_q;
        cpu_rst      = cpu_rst_q;
        done         = done_q;
        err          = err_q;
        words_loaded = words_loaded_q;
        dbg_state    = state_q;
    end

endmodule
